// File: rtl/tone_freq_meter.sv
// Tone frequency meter: synchronizes and deglitches a square-wave input, counts rising edges over
// a fixed gate window and reports Hz. Define TONE_METER_PERIOD_EN to add edge-to-edge period capture.
module tone_freq_meter #(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned GATE_SHIFT    = 3,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned SILENT_HZ     = 20000,
  parameter int unsigned TOL_HZ        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        tone_in,
  output logic [31:0] freq,
  output logic        freq_valid,
  output logic        silent,
  output logic        freq_stable,
  output logic [31:0] period_cyc
);

  localparam int unsigned GateLen = CLK_HZ >> GATE_SHIFT;
  localparam int unsigned EdgeW   = 32 - GATE_SHIFT;
  localparam int unsigned GlW     = $clog2(GLITCH_CYCLES + 1);
  localparam logic [31:0]      GateLast = 32'(GateLen - 1);
  localparam logic [EdgeW-1:0] EdgeMax  = '1;
  localparam logic [GlW-1:0]   GlLast   = GlW'(GLITCH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGate, StReport} state_e;

  logic           sync1_q, sync2_q, filt_q, rise_q;
  logic [GlW-1:0] gl_cnt_q;

  // Synchronizer and glitch filter run regardless of en so the filtered level is never stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_q   <= 1'b0;
      rise_q   <= 1'b0;
      gl_cnt_q <= '0;
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == filt_q) begin
        gl_cnt_q <= '0;
      end else if (gl_cnt_q == GlLast) begin
        filt_q   <= sync2_q;
        rise_q   <= sync2_q;
        gl_cnt_q <= '0;
      end else begin
        gl_cnt_q <= gl_cnt_q + GlW'(1);
      end
    end
  end

  state_e           state_q, state_d;
  logic [31:0]      gate_cnt_q, gate_cnt_d;
  logic [EdgeW-1:0] edge_cnt_q, edge_cnt_d, edge_total;
  logic [31:0]      freq_q, freq_d, new_freq, delta;
  logic             silent_q, silent_d, stable_q, stable_d, prev_ok_q, prev_ok_d;

  assign edge_total = (rise_q && (edge_cnt_q != EdgeMax)) ? edge_cnt_q + EdgeW'(1) : edge_cnt_q;
  assign new_freq   = 32'(edge_total) << GATE_SHIFT;
  assign delta      = (new_freq >= freq_q) ? new_freq - freq_q : freq_q - new_freq;

  // Results latch on the last gate cycle so they are already valid while freq_valid is high.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    freq_d     = freq_q;
    silent_d   = silent_q;
    stable_d   = stable_q;
    prev_ok_d  = prev_ok_q;
    case (state_q)
      StIdle: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        prev_ok_d  = 1'b0;
        if (en) state_d = StGate;
      end
      StGate: begin
        if (!en) begin
          state_d    = StIdle;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          prev_ok_d  = 1'b0;
        end else if (gate_cnt_q == GateLast) begin
          state_d    = StReport;
          freq_d     = new_freq;
          silent_d   = (edge_total == '0) || (new_freq >= SILENT_HZ);
          stable_d   = prev_ok_q && (delta <= TOL_HZ);
          prev_ok_d  = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
        end else begin
          gate_cnt_d = gate_cnt_q + 32'd1;
          edge_cnt_d = edge_total;
        end
      end
      StReport: state_d = en ? StGate : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      silent_q   <= 1'b1;
      stable_q   <= 1'b0;
      prev_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      silent_q   <= silent_d;
      stable_q   <= stable_d;
      prev_ok_q  <= prev_ok_d;
    end
  end

  assign freq        = freq_q;
  assign silent      = silent_q;
  assign freq_stable = stable_q;
  assign freq_valid  = (state_q == StReport);

`ifdef TONE_METER_PERIOD_EN
  logic [31:0] per_cnt_q, period_q;
  logic        armed_q;

  // The first edge after reset or enable only arms the counter; later edges capture a period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      armed_q   <= 1'b0;
    end else begin
      if (rise_q) begin
        per_cnt_q <= '0;
        armed_q   <= en;
        if (armed_q && en) period_q <= (per_cnt_q == '1) ? '1 : per_cnt_q + 32'd1;
      end else begin
        if (!en) armed_q <= 1'b0;
        if (per_cnt_q != '1) per_cnt_q <= per_cnt_q + 32'd1;
      end
    end
  end

  assign period_cyc = period_q;
`else
  assign period_cyc = '0;
`endif

endmodule
